// File: rtl/jt49_pkg.sv
// Shared constants for the PSG bus controller: register indices, AY bus codes
// and the per-register write-mask table.
package jt49_pkg;

    localparam int NUM_REGS = 16;

    localparam logic [3:0] R_NOISE     = 4'd6;
    localparam logic [3:0] R_MIX       = 4'd7;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;

    // {bdir, bc1}
    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_LATCH = 2'b11;

    // Bits that physically exist in each register; the rest read back as 0.
    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        logic [7:0] m;
        case (idx)
            4'd1, 4'd3, 4'd5, 4'd13: m = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: m = 8'h1F;
            default:                 m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/jt49_cen_gen.sv
// Datapath clock-enable generator: free-running 4-bit counter, cen every 8 or
// 16 clocks, with the rate select only taking effect at counter wrap.
module jt49_cen_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    output logic cen
);
    logic [3:0] cnt_reg;
    logic       mode_reg;
    logic       wrap;

    assign wrap = (cnt_reg == 4'hF);

    // mode_reg starts in the 8-clk rate so the first period after reset is
    // never longer than a full wrap; sel is then adopted at each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= 4'h0;
            mode_reg <= 1'b1;
        end else begin
            cnt_reg <= cnt_reg + 4'd1;
            if (wrap) begin
                mode_reg <= sel;
            end
        end
    end

    assign cen = mode_reg ? (cnt_reg[2:0] == 3'h7) : wrap;

endmodule

// File: rtl/jt49_bus_ctrl.sv
// AY-3-8910 style bus front end: BDIR/BC1 decode, masked 16-entry register
// file, registered read port, datapath pacing and control strobes.
module jt49_bus_ctrl
    import jt49_pkg::*;
#(
    parameter logic [3:0] CHIP_ADDR = 4'd0,
    parameter logic [7:0] RESET_MIX = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bdir,
    input  logic         bc1,
    input  logic [7:0]   din,
    input  logic         sel,
    output logic [7:0]   dout,
    output logic         cen,
    output logic [4:0]   noise_period,
    output logic [2:0]   tone_en_n,
    output logic [2:0]   noise_en_n,
    output logic         env_restart,
    output logic [127:0] regs_flat
);
    logic [1:0] bus_code;
    logic       is_read;
    logic       is_write;
    logic       is_latch;

    logic [3:0] addr_reg;
    logic       chip_sel_reg;
    logic       write_prev_reg;
    logic       commit_next;

    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] dout_reg;
    logic [7:0] dout_next;
    logic [4:0] noise_reg;
    logic       env_reg;

    assign bus_code = {bdir, bc1};

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        is_latch = 1'b0;
        case (bus_code)
            BUS_IDLE:  ;
            BUS_READ:  is_read  = 1'b1;
            BUS_WRITE: is_write = 1'b1;
            BUS_LATCH: is_latch = 1'b1;
        endcase
    end

    // write_prev_reg resets high so a WRITE still held across reset release
    // is not mistaken for a fresh entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= 4'h0;
            chip_sel_reg   <= 1'b1;
            write_prev_reg <= 1'b1;
        end else begin
            write_prev_reg <= is_write;
            if (is_latch) begin
                addr_reg     <= din[3:0];
                chip_sel_reg <= (din[7:4] == CHIP_ADDR);
            end
        end
    end

    assign commit_next = is_write && !write_prev_reg && chip_sel_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [3:0] IDX  = 4'(gi);
            localparam logic [7:0] MASK = reg_mask(IDX);
            localparam logic [7:0] INIT = (IDX == R_MIX) ? RESET_MIX : 8'h00;

            logic [7:0] val_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg <= INIT;
                end else if (commit_next && (addr_reg == IDX)) begin
                    val_reg <= din & MASK;
                end
            end

            assign regs_q[gi]            = val_reg;
            assign regs_flat[gi*8 +: 8]  = val_reg;
        end
    endgenerate

    assign dout_next = (is_read && chip_sel_reg) ? regs_q[addr_reg] : 8'hFF;

    jt49_cen_gen u_cen_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .cen   (cen)
    );

    // The noise shadow samples R6 on cen cycles only, so a commit landing on a
    // cen cycle is picked up by the following cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg  <= 8'hFF;
            noise_reg <= 5'h00;
            env_reg   <= 1'b0;
        end else begin
            dout_reg <= dout_next;
            env_reg  <= commit_next && (addr_reg == R_ENV_SHAPE);
            if (cen) begin
                noise_reg <= regs_q[R_NOISE][4:0];
            end
        end
    end

    assign dout         = dout_reg;
    assign noise_period = noise_reg;
    assign env_restart  = env_reg;
    assign tone_en_n    = regs_q[R_MIX][2:0];
    assign noise_en_n   = regs_q[R_MIX][5:3];

endmodule

// File: tb/tb_jt49_bus_ctrl.sv
// Directed bench for jt49_bus_ctrl: a behavioural bus/register model checked
// against the DUT every clock, plus hand-computed literal expectations.
module tb_jt49_bus_ctrl;

    localparam logic [3:0] CHIP = 4'd0;
    localparam logic [1:0] C_IDLE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_LATCH = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         bdir = 1'b0;
    logic         bc1 = 1'b0;
    logic [7:0]   din = 8'h00;
    logic         sel = 1'b1;
    logic [7:0]   dout;
    logic         cen;
    logic [4:0]   noise_period;
    logic [2:0]   tone_en_n;
    logic [2:0]   noise_en_n;
    logic         env_restart;
    logic [127:0] regs_flat;

    always #5 clk = ~clk;

    jt49_bus_ctrl #(.CHIP_ADDR(CHIP), .RESET_MIX(8'hFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bdir         (bdir),
        .bc1          (bc1),
        .din          (din),
        .sel          (sel),
        .dout         (dout),
        .cen          (cen),
        .noise_period (noise_period),
        .tone_en_n    (tone_en_n),
        .noise_en_n   (noise_en_n),
        .env_restart  (env_restart),
        .regs_flat    (regs_flat)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [16];
    logic [3:0] m_addr;
    bit         m_chip;
    bit         m_in_write;
    int         m_cyc;
    bit         m_fast;
    logic [4:0] m_noise;
    logic [7:0] m_dout;
    bit         m_env;

    function automatic logic [7:0] spec_mask(input logic [3:0] a);
        if (a == 4'd1 || a == 4'd3 || a == 4'd5 || a == 4'd13) return 8'h0F;
        if (a == 4'd6 || a == 4'd8 || a == 4'd9 || a == 4'd10) return 8'h1F;
        return 8'hFF;
    endfunction

    function automatic bit model_cen();
        return m_fast ? (m_cyc % 8 == 7) : (m_cyc % 16 == 15);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = (i == 7) ? 8'hFF : 8'h00;
        m_addr = 4'h0; m_chip = 1'b1; m_in_write = 1'b1;
        m_cyc = 0; m_fast = 1'b1; m_noise = 5'h00; m_dout = 8'hFF; m_env = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] code;
        logic [7:0] rd;
        bit         wr;
        code = {bdir, bc1};
        rd = (code == C_READ && m_chip) ? m_regs[m_addr] : 8'hFF;
        if (model_cen()) m_noise = m_regs[6][4:0];
        wr = (code == C_WRITE) && !m_in_write && m_chip;
        m_env = wr && (m_addr == 4'd13);
        if (wr) m_regs[m_addr] = din & spec_mask(m_addr);
        if (code == C_LATCH) begin
            m_addr = din[3:0];
            m_chip = (din[7:4] == CHIP);
        end
        m_in_write = (code == C_WRITE);
        if (m_cyc % 16 == 15) m_fast = sel;
        m_cyc++;
        m_dout = rd;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                logic [127:0] ef;
                for (int i = 0; i < 16; i++) ef[i*8 +: 8] = m_regs[i];
                check("cyc_cen", 128'(cen), 128'(model_cen()));
                check("cyc_dout", 128'(dout), 128'(m_dout));
                check("cyc_noise_period", 128'(noise_period), 128'(m_noise));
                check("cyc_tone_en_n", 128'(tone_en_n), 128'(m_regs[7][2:0]));
                check("cyc_noise_en_n", 128'(noise_en_n), 128'(m_regs[7][5:3]));
                check("cyc_env_restart", 128'(env_restart), 128'(m_env));
                check("cyc_regs_flat", regs_flat, ef);
            end
        end
    end

    int env_pulses = 0;
    initial forever begin
        @(negedge clk);
        if (env_restart) env_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic [1:0] code, input logic [7:0] d, input int n);
        {bdir, bc1} = code;
        din = d;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        bus(C_LATCH, {CHIP, a}, 1);
        bus(C_WRITE, d, 1);
        bus(C_IDLE, 8'h00, 1);
        $display("write R%0d <= %h", a, d);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
        bus(C_LATCH, {CHIP, a}, 1);
        bus(C_READ, 8'h00, 1);
        v = dout;
        bus(C_IDLE, 8'h00, 1);
        $display("read  R%0d -> %h", a, v);
    endtask

    task automatic wait_cen();
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = cen;
        end
        #1;
        check("wait_cen_timeout", 128'(got), 128'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test ----------------
    initial begin
        logic [7:0] v;
        int first, last, npulse, e0;
        bit gap_ok;
        int pos [5];
        int exp_pos [5];
        exp_pos = '{7, 15, 31, 47, 63};

        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dout", 128'(dout), 128'(8'hFF));
        check("rst_cen", 128'(cen), 128'(1'b0));
        check("rst_noise", 128'(noise_period), 128'(5'h00));
        check("rst_regs_flat", regs_flat, 128'h0000000000000000_FF00000000000000);
        check("rst_env", 128'(env_restart), 128'(1'b0));
        rst_n = 1'b1;
        $display("reset released");

        // cen pacing at sel=1
        first = -1; last = -1; npulse = 0; gap_ok = 1'b1;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (cen) begin
                if (first < 0) first = j;
                else if (j - last != 8) gap_ok = 1'b0;
                last = j;
                npulse++;
            end
        end
        #1;
        check("cen_first", 128'(first), 128'(7));
        check("cen_count64", 128'(npulse), 128'(8));
        check("cen_gap8", 128'(gap_ok), 128'(1'b1));

        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            check($sformatf("rst_R%0d", i), 128'(v), 128'((i == 7) ? 8'hFF : 8'h00));
        end

        // R6 held WRITE: one commit with the first-clk data
        bus(C_LATCH, 8'h06, 1);
        bus(C_WRITE, 8'hFF, 1);
        check("noise_before_cen", 128'(noise_period), 128'(5'h00));
        bus(C_WRITE, 8'h03, 4);
        bus(C_IDLE, 8'h00, 1);
        $display("write R6 <= ff (held 5 clks)");
        read_reg(4'd6, v);
        check("R6_single_commit", 128'(v), 128'(8'h1F));
        wait_cen();
        @(negedge clk); #1;
        check("noise_1F", 128'(noise_period), 128'(5'h1F));

        // R6 commit coinciding with cen
        bus(C_LATCH, 8'h06, 1);
        bus(C_IDLE, 8'h00, 1);
        wait_cen();
        bus(C_WRITE, 8'h0A, 1);
        $display("write R6 <= 0a on cen");
        check("noise_hold_same_cen", 128'(noise_period), 128'(5'h1F));
        bus(C_IDLE, 8'h00, 1);
        wait_cen();
        check("noise_hold_next_cen", 128'(noise_period), 128'(5'h1F));
        @(negedge clk); #1;
        check("noise_0A", 128'(noise_period), 128'(5'h0A));

        // wrong chip address
        bus(C_LATCH, 8'h17, 1);
        bus(C_WRITE, 8'h55, 1);
        bus(C_IDLE, 8'h00, 1);
        bus(C_READ, 8'h00, 1);
        $display("read deselected -> %h", dout);
        check("desel_read", 128'(dout), 128'(8'hFF));
        bus(C_IDLE, 8'h00, 1);
        check("desel_regs", regs_flat, 128'h0000000000000000_FF0A000000000000);
        write_reg(4'd7, 8'h2A);
        check("tone_en_n_2A", 128'(tone_en_n), 128'(3'b010));
        check("noise_en_n_2A", 128'(noise_en_n), 128'(3'b101));

        // envelope restart
        e0 = env_pulses;
        bus(C_LATCH, 8'h0D, 1);
        bus(C_WRITE, 8'h0E, 1);
        $display("write R13 <= 0e");
        check("env_high", 128'(env_restart), 128'(1'b1));
        bus(C_IDLE, 8'h00, 1);
        check("env_low", 128'(env_restart), 128'(1'b0));
        bus(C_WRITE, 8'h0E, 3);
        bus(C_IDLE, 8'h00, 2);
        $display("write R13 <= 0e (held 3 clks)");
        check("env_two_pulses", 128'(env_pulses - e0), 128'(2));
        read_reg(4'd13, v);
        check("R13_0E", 128'(v), 128'(8'h0E));
        write_reg(4'd13, 8'hFE);
        check("env_three_pulses", 128'(env_pulses - e0), 128'(3));
        read_reg(4'd13, v);
        check("R13_mask", 128'(v), 128'(8'h0E));

        // masks and read-after-write
        write_reg(4'd8, 8'hFF);
        read_reg(4'd8, v);
        check("R8_mask", 128'(v), 128'(8'h1F));
        write_reg(4'd1, 8'hFF);
        read_reg(4'd1, v);
        check("R1_mask", 128'(v), 128'(8'h0F));
        write_reg(4'd0, 8'hA5);
        read_reg(4'd0, v);
        check("R0_full", 128'(v), 128'(8'hA5));
        bus(C_LATCH, 8'h02, 1);
        bus(C_WRITE, 8'h3C, 1);
        bus(C_READ, 8'h00, 1);
        $display("write R2 <= 3c, read back %h", dout);
        check("raw_R2", 128'(dout), 128'(8'h3C));
        bus(C_IDLE, 8'h00, 1);

        // reset mid-WRITE, then sel 1->0 at cnt=5
        bus(C_LATCH, 8'h00, 1);
        bus(C_WRITE, 8'h77, 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset pulsed during WRITE");
        npulse = 0;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (cen) begin
                if (npulse < 5) pos[npulse] = j;
                npulse++;
            end
            #1;
            if (j == 3) {bdir, bc1} = C_IDLE;
            if (j == 5) sel = 1'b0;
        end
        check("sel_pulse_count", 128'(npulse), 128'(5));
        for (int p = 0; p < 5; p++) begin
            check($sformatf("sel_pulse%0d", p), 128'(pos[p]), 128'(exp_pos[p]));
        end
        bus(C_READ, 8'h00, 1);
        $display("read R0 after reset -> %h", dout);
        check("no_commit_after_rst", 128'(dout), 128'(8'h00));
        bus(C_WRITE, 8'h77, 1);
        bus(C_IDLE, 8'h00, 1);
        bus(C_READ, 8'h00, 1);
        $display("write R0 <= 77 (reset address), read back %h", dout);
        check("rst_addr_selected", 128'(dout), 128'(8'h77));
        bus(C_IDLE, 8'h00, 2);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
